// File: rtl/booth_mult.sv
// booth_mult: sequential signed radix-2 Booth multiplier for MULT.
// Each clock performs one Booth iteration. After WIDTH iterations the full
// 2*WIDTH-bit product is written to hi/lo, and mult_stop pulses for one cycle.
module booth_mult #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_control,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             mult_stop
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_r, state_s;

    // The multiplicand is sign-extended by one bit. The accumulator is one bit
    // wider than an operand, so it can hold -M when A is the most negative value.
    logic [WIDTH:0]    m_r,   m_s;
    logic [WIDTH:0]    acc_r, acc_s;
    logic [WIDTH:0]    sum_s;
    logic [WIDTH-1:0]  q_r,   q_s;
    logic              q1_r,  q1_s;
    logic [CW-1:0]     cnt_r, cnt_s;
    logic [WIDTH-1:0]  hi_r,  hi_s;
    logic [WIDTH-1:0]  lo_r,  lo_s;
    logic              stop_r, stop_s;

    // Booth recoding: add or subtract M from the accumulator based on {Q[0], Q_1}.
    always_comb begin
        sum_s = acc_r;
        case ({q_r[0], q1_r})
            2'b01:   sum_s = acc_r + m_r;
            2'b10:   sum_s = acc_r - m_r;
            default: sum_s = acc_r;
        endcase
    end

    // Next-state and datapath logic. A start pulse in any state reloads the
    // operands and restarts the operation, which aborts any running operation.
    always_comb begin
        state_s = state_r;
        m_s     = m_r;
        acc_s   = acc_r;
        q_s     = q_r;
        q1_s    = q1_r;
        cnt_s   = cnt_r;
        hi_s    = hi_r;
        lo_s    = lo_r;
        stop_s  = 1'b0;
        if (mult_control) begin
            m_s     = {A[WIDTH-1], A};
            acc_s   = '0;
            q_s     = B;
            q1_s    = 1'b0;
            cnt_s   = CW'(WIDTH);
            hi_s    = '0;
            lo_s    = '0;
            state_s = RUN;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                RUN: begin
                    // Arithmetic right shift of {ACC, Q, Q_1}; ACC's sign bit is replicated.
                    acc_s = {sum_s[WIDTH], sum_s[WIDTH:1]};
                    q_s   = {sum_s[0], q_r[WIDTH-1:1]};
                    q1_s  = q_r[0];
                    cnt_s = cnt_r - CW'(1);
                    if (cnt_r == CW'(1)) begin
                        state_s = DONE;
                    end else begin
                        state_s = RUN;
                    end
                end
                DONE: begin
                    hi_s    = acc_r[WIDTH-1:0];
                    lo_s    = q_r;
                    stop_s  = 1'b1;
                    state_s = IDLE;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers. Reset asynchronously clears all of them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            m_r     <= '0;
            acc_r   <= '0;
            q_r     <= '0;
            q1_r    <= 1'b0;
            cnt_r   <= '0;
            hi_r    <= '0;
            lo_r    <= '0;
            stop_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            m_r     <= m_s;
            acc_r   <= acc_s;
            q_r     <= q_s;
            q1_r    <= q1_s;
            cnt_r   <= cnt_s;
            hi_r    <= hi_s;
            lo_r    <= lo_s;
            stop_r  <= stop_s;
        end
    end

    assign hi        = hi_r;
    assign lo        = lo_r;
    assign mult_stop = stop_r;

endmodule

// File: tb/tb_booth_mult.sv
// tb_booth_mult: table-driven checks with a scoreboard for booth_mult.
module tb_booth_mult;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mult_control = 1'b0;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          mult_stop;

    int errors = 0;
    int checks = 0;
    logic [2*W-1:0] exp_q[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    vec_t vecs[10];

    booth_mult #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .mult_control (mult_control),
        .A            (A),
        .B            (B),
        .hi           (hi),
        .lo           (lo),
        .mult_stop    (mult_stop)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Scoreboard: each mult_stop pulse must match the oldest outstanding product.
    always @(negedge clk) begin
        if (!reset && mult_stop) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_stop: got stop with hi=%h lo=%h, expected none", hi, lo);
            end else begin
                check("product", {hi, lo}, exp_q.pop_front());
            end
        end
    end

    // A new start aborts any outstanding operation, so only one product is pending.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        A = a;
        B = b;
        mult_control = 1'b1;
        exp_q.delete();
        exp_q.push_back(64'(longint'($signed(a)) * longint'($signed(b))));
        @(posedge clk);
        #1;
        mult_control = 1'b0;
        A = $urandom;
        B = $urandom;
    endtask

    // Expects mult_stop low on edges 1..edges-1, high at `edges`, and low at edges+1.
    task automatic wait_done(input int edges, input string name);
        for (int k = 1; k <= edges + 1; k++) begin
            @(posedge clk);
            #1;
            check(name, 64'(mult_stop), (k == edges) ? 64'd1 : 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{32'd3,          32'd5,          32'h0000_0000, 32'h0000_000F};
        vecs[1] = '{32'hFFFF_FFF9,  32'd6,          32'hFFFF_FFFF, 32'hFFFF_FFD6};
        vecs[2] = '{32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 32'h0000_0000};
        vecs[3] = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000};
        vecs[4] = '{32'h7FFF_FFFF,  32'h7FFF_FFFF,  32'h3FFF_FFFF, 32'h0000_0001};
        vecs[5] = '{32'h0000_0000,  32'hDEAD_BEEF,  32'h0000_0000, 32'h0000_0000};
        vecs[6] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 32'h0000_0001};
        vecs[7] = '{32'h0001_0000,  32'hFFFF_0000,  32'hFFFF_FFFF, 32'h0000_0000};
        vecs[8] = '{32'h1234_5678,  32'h0000_0010,  32'h0000_0001, 32'h2345_6780};
        vecs[9] = '{32'hFFFF_FFFE,  32'h8000_0001,  32'h0000_0000, 32'hFFFF_FFFE};

        // Reset state
        #1;
        check("reset_state", {hi, lo, 63'(mult_stop)} >> 63, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Table of products with latency and hold checks
        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            wait_done(LAT, $sformatf("stop_timing_%0d", i));
            check($sformatf("hold_%0d", i), {hi, lo}, {vecs[i].hi, vecs[i].lo});
        end

        // A restart at E10 aborts 3*5; only -2*4 completes, 33 edges later
        start_op(32'd3, 32'd5);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            check("abort_no_stop", 64'(mult_stop), 64'd0);
        end
        start_op(32'hFFFF_FFFE, 32'd4);
        wait_done(LAT, "abort_restart");
        check("abort_result", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF8);

        // Start held high for three edges; the last sampled operands win
        @(negedge clk);
        A = 32'd1;
        B = 32'd1;
        mult_control = 1'b1;
        @(posedge clk);
        #1;
        check("held_clears", {hi, lo}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        A = 32'd5;
        B = 32'hFFFF_FFFD;
        exp_q.delete();
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFF1);
        @(posedge clk);
        #1;
        mult_control = 1'b0;
        wait_done(LAT, "held_start");
        check("held_result", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

        // Reset with nonzero held outputs clears them immediately
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_idle_clear", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Reset mid-operation at E15: no stop pulse, then a clean restart
        start_op(32'd3, 32'd5);
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("reset_mid_hilo", {hi, lo}, 64'd0);
        check("reset_mid_stop", 64'(mult_stop), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            check("reset_no_stop", 64'(mult_stop), 64'd0);
        end
        start_op(32'd3, 32'd5);
        wait_done(LAT, "after_reset");
        check("after_reset_result", {hi, lo}, 64'h0000_0000_0000_000F);

        // Every expected product must have been consumed
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
